// File: rtl/ddr3_mcb_arb.sv
// Two-port request arbiter in front of a DDR3 memory controller block, with open-row classification.
// Optional macro DDR3_MCB_ARB_RR_EN selects round-robin arbitration; otherwise p0 has fixed priority.
module ddr3_mcb_arb #(
    parameter int MCB_B_W  = 3,
    parameter int MCB_R_W  = 14,
    parameter int MCB_C_W  = 10,
    parameter int MCB_D_W  = 64,
    parameter int MCB_BE_W = 8
) (
    input  logic                ddr3_mcb_clk,
    input  logic                ddr3_mcb_rst,

    input  logic                p0_req,
    output logic                p0_ack,
    input  logic                p0_wr_n,
    input  logic [1:0]          p0_bl,
    input  logic [MCB_B_W-1:0]  p0_ba,
    input  logic [MCB_R_W-1:0]  p0_ra,
    input  logic [MCB_C_W-1:0]  p0_ca,
    input  logic [MCB_D_W-1:0]  p0_wdat,
    input  logic [MCB_BE_W-1:0] p0_wbe,
    output logic                p0_wdat_req,
    output logic                p0_rdat_vld,

    input  logic                p1_req,
    output logic                p1_ack,
    input  logic                p1_wr_n,
    input  logic [1:0]          p1_bl,
    input  logic [MCB_B_W-1:0]  p1_ba,
    input  logic [MCB_R_W-1:0]  p1_ra,
    input  logic [MCB_C_W-1:0]  p1_ca,
    input  logic [MCB_D_W-1:0]  p1_wdat,
    input  logic [MCB_BE_W-1:0] p1_wbe,
    output logic                p1_wdat_req,
    output logic                p1_rdat_vld,

    input  logic                i_ready,
    input  logic                ref_prea,
    input  logic                ddr3_mcb_busy,
    input  logic                ddr3_mcb_wdat_req,
    input  logic                ddr3_mcb_rdat_vld,
    output logic                row_hit,
    output logic                row_miss,
    output logic                row_empty,
    output logic                ddr3_mcb_wr_n,
    output logic [1:0]          ddr3_mcb_bl,
    output logic [MCB_B_W-1:0]  ddr3_mcb_ba,
    output logic [MCB_R_W-1:0]  ddr3_mcb_ra,
    output logic [MCB_C_W-1:0]  ddr3_mcb_ca,
    output logic [MCB_D_W-1:0]  ddr3_mcb_wdat,
    output logic [MCB_BE_W-1:0] ddr3_mcb_wbe,
    output logic                arb_err
);

    localparam int NBANK = 1 << MCB_B_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           tmo_cnt_q, tmo_cnt_d;
    logic                 tmo;
    logic                 grant;
    logic                 winner;
    logic                 owner_q;
    logic                 owner_sel;
    logic                 owned;

    logic                 wr_n_q;
    logic [1:0]           bl_q;
    logic [MCB_B_W-1:0]   ba_q;
    logic [MCB_R_W-1:0]   ra_q;
    logic [MCB_C_W-1:0]   ca_q;
    logic                 arb_err_q;

    logic [NBANK-1:0]     row_vld_q;
    logic [MCB_R_W-1:0]   row_tbl_q [NBANK];
    logic                 in_issue;
    logic                 row_match;

    // A grant is a combinational decision in IDLE so the ack pulses in the same cycle.
    assign grant = (state_q == ST_IDLE) && i_ready && !ddr3_mcb_busy && !ref_prea
                   && (p0_req || p1_req) && !ddr3_mcb_rst;

`ifdef DDR3_MCB_ARB_RR_EN
    logic favor_p1_q;

    assign winner = p1_req && (!p0_req || favor_p1_q);

    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst)
            favor_p1_q <= 1'b0;
        else if (grant)
            favor_p1_q <= !winner;
    end
`else
    assign winner = !p0_req;
`endif

    assign p0_ack = grant && !winner;
    assign p1_ack = grant && winner;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (ddr3_mcb_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == 4'd15) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!ddr3_mcb_busy)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr3_mcb_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (ddr3_mcb_rst) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            owner_q   <= 1'b0;
            wr_n_q    <= 1'b0;
            bl_q      <= '0;
            ba_q      <= '0;
            ra_q      <= '0;
            ca_q      <= '0;
            arb_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo)
                arb_err_q <= 1'b1;
            if (grant) begin
                owner_q <= winner;
                wr_n_q  <= winner ? p1_wr_n : p0_wr_n;
                bl_q    <= winner ? p1_bl   : p0_bl;
                ba_q    <= winner ? p1_ba   : p0_ba;
                ra_q    <= winner ? p1_ra   : p0_ra;
                ca_q    <= winner ? p1_ca   : p0_ca;
            end
        end
    end

    // Precharge-all invalidates every open row and overrides the ISSUE update.
    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst || ref_prea)
            row_vld_q <= '0;
        else if (state_q == ST_ISSUE)
            row_vld_q[ba_q] <= 1'b1;
    end

    always_ff @(posedge ddr3_mcb_clk) begin
        // NOTE: the row storage is deliberately not reset; the valid bits alone qualify its contents.
        if (!ddr3_mcb_rst && !ref_prea && state_q == ST_ISSUE)
            row_tbl_q[ba_q] <= ra_q;
    end

    assign in_issue  = (state_q == ST_ISSUE) && !ddr3_mcb_rst;
    assign row_match = (row_tbl_q[ba_q] == ra_q);
    assign row_hit   = in_issue && row_vld_q[ba_q] && row_match;
    assign row_miss  = in_issue && row_vld_q[ba_q] && !row_match;
    assign row_empty = in_issue && !row_vld_q[ba_q];

    // Ownership spans the ack cycle through the return to IDLE.
    assign owned     = grant || ((state_q != ST_IDLE) && !ddr3_mcb_rst);
    assign owner_sel = grant ? winner : owner_q;

    assign p0_wdat_req = owned && !owner_sel && ddr3_mcb_wdat_req;
    assign p1_wdat_req = owned &&  owner_sel && ddr3_mcb_wdat_req;
    assign p0_rdat_vld = owned && !owner_sel && ddr3_mcb_rdat_vld;
    assign p1_rdat_vld = owned &&  owner_sel && ddr3_mcb_rdat_vld;

    always_comb begin
        ddr3_mcb_wdat = '0;
        ddr3_mcb_wbe  = '0;
        if (owned) begin
            ddr3_mcb_wdat = owner_sel ? p1_wdat : p0_wdat;
            ddr3_mcb_wbe  = owner_sel ? p1_wbe  : p0_wbe;
        end
    end

    assign ddr3_mcb_wr_n = wr_n_q;
    assign ddr3_mcb_bl   = bl_q;
    assign ddr3_mcb_ba   = ba_q;
    assign ddr3_mcb_ra   = ra_q;
    assign ddr3_mcb_ca   = ca_q;
    assign arb_err       = arb_err_q;

endmodule

// File: doc/ddr3_mcb_arb.md
DDR3_MCB_ARB -- requirements
Module: ddr3_mcb_arb

Interface
REQ-001 SHALL have parameter MCB_B_W, default 3, bank address width; MCB_R_W, default 14, row width; MCB_C_W, default 10, column width; MCB_D_W, default 64, user data width; MCB_BE_W, default 8, byte-enable width.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
- ddr3_mcb_clk  in  1  rising-edge clock.
- ddr3_mcb_rst  in  1  synchronous active-high reset.
REQ-003 SHALL have two identical requester ports, pN for N=0,1:
- pN_req  in  1  request; held until pN_ack.
- pN_ack  out  1  one-cycle pulse; request accepted.
- pN_wr_n  in  1  0=write, 1=read.
- pN_bl  in  2  burst length code.
- pN_ba / pN_ra / pN_ca  in  MCB_B_W / MCB_R_W / MCB_C_W  bank / row / column.
- pN_wdat  in  MCB_D_W  write data; pN_wbe  in  MCB_BE_W  byte enables.
- pN_wdat_req  out  1  write data strobe.
- pN_rdat_vld  out  1  read data valid.
REQ-004 SHALL have the MCB-side ports:
- i_ready  in  1  init done.
- ref_prea  in  1  pulse; precharge-all issued.
- ddr3_mcb_busy, ddr3_mcb_wdat_req, ddr3_mcb_rdat_vld  in  1.
- row_hit, row_miss, row_empty  out  1.
- ddr3_mcb_wr_n  out  1; ddr3_mcb_bl  out  2.
- ddr3_mcb_ba / ddr3_mcb_ra / ddr3_mcb_ca  out  MCB_B_W / MCB_R_W / MCB_C_W.
- ddr3_mcb_wdat  out  MCB_D_W; ddr3_mcb_wbe  out  MCB_BE_W.
- arb_err  out  1  sticky busy timeout flag.

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
REQ-006 IDLE: when i_ready=1, busy=0, ref_prea=0 and any pN_req=1, SHALL select a winner, latch its fields, pulse its pN_ack the same cycle, and go to ISSUE.
REQ-007 ISSUE: SHALL assert exactly one of row_hit/row_miss/row_empty for one cycle, with latched wr_n/bl/ba/ra/ca on the ddr3_mcb_* outputs; next state WAIT_BUSY.
REQ-008 Classification uses an 2^MCB_B_W-entry open-row table {valid, row}: valid and row equal = hit; valid and row differ = miss; not valid = empty.
REQ-009 In ISSUE, the table entry for the latched bank SHALL become {1, latched ra}.
REQ-010 WAIT_BUSY: on busy=1, go to WAIT_DONE; if busy stays 0 for 16 cycles, set arb_err and return to IDLE.
REQ-011 WAIT_DONE: on busy=0, go to IDLE; the next grant is possible no earlier than the following cycle.
REQ-012 From ACK to return to IDLE, pN_wdat_req and pN_rdat_vld SHALL be the MCB strobes gated to the owner port only.
REQ-013 ddr3_mcb_wdat/ddr3_mcb_wbe SHALL mux combinationally from the owner port; outside ownership they SHALL be 0.
REQ-014 ref_prea=1 SHALL clear all table valid bits in that cycle; ref_prea wins over a simultaneous ISSUE update; ref_prea in IDLE blocks grant that cycle.
REQ-015 Address/control outputs SHALL hold latched values outside ISSUE; row_* are 0 outside ISSUE.

Reset
REQ-016 On ddr3_mcb_rst=1 at a clock edge: state=IDLE; all valid bits=0; all pN_ack, pN_wdat_req, pN_rdat_vld, row_* and arb_err=0; ddr3_mcb_* address/control and data=0; round-robin pointer favors p0.
REQ-017 Reset mid-transaction SHALL abandon the transaction without issuing pN_ack or strobes.

Configuration
REQ-018 With macro DDR3_MCB_ARB_RR_EN defined: round-robin arbitration; the last-granted port has lowest priority on the next contention.
REQ-019 Without DDR3_MCB_ARB_RR_EN: fixed priority, p0 over p1.

Verification
REQ-020 After reset, i_ready=1, p0 read ba=2 ra=0x100 -> row_empty pulse, p0_ack, table[2]={1,0x100}.
REQ-021 Then p0 ba=2 ra=0x100 -> row_hit; then ba=2 ra=0x200 -> row_miss.
REQ-022 With p0 and p1 both requesting continuously: RR_EN grants alternate p0,p1,p0; without RR_EN, grants are p0 only.
REQ-023 Pulse ref_prea after a row open, then request ba=2 ra=0x100 -> row_empty.
REQ-024 Issue with busy held 0 for 16 cycles -> arb_err=1, FSM in IDLE, next request served.
REQ-025 p1 write while owner: ddr3_mcb_wdat_req pulses -> only p1_wdat_req is asserted and ddr3_mcb_wdat equals p1_wdat.
